// File: rtl/controller_input_conditioner_pkg.sv
// Shared types for the controller input conditioner.
// Glitch counting is built only when CONTROLLER_GLITCH_COUNT_EN is defined.
package controller_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_SYM  = 2'd2,
        MODE_PASS = 2'd3
    } filter_mode_e;

    localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/controller_input_conditioner_if.sv
// Pad, logic-analyser and conditioned-level bundle of the input conditioner.
// Master drives the pads and controls; slave is the conditioner.
interface controller_input_conditioner_if #(
    parameter int NUM_CHANNELS = 3
);

    logic [NUM_CHANNELS-1:0]   io_in;
    logic [NUM_CHANNELS-1:0]   io_oeb;
    logic [2*NUM_CHANNELS-1:0] la_data_in;
    logic [2*NUM_CHANNELS-1:0] la_oenb;
    logic [2*NUM_CHANNELS-1:0] filter_mode;
    logic [NUM_CHANNELS-1:0]   level_out;
    logic [NUM_CHANNELS-1:0]   rise_pulse;
    logic [NUM_CHANNELS-1:0]   fall_pulse;

    modport master (
        output io_in, la_data_in, la_oenb, filter_mode,
        input  io_oeb, level_out, rise_pulse, fall_pulse
    );

    modport slave (
        input  io_in, la_data_in, la_oenb, filter_mode,
        output io_oeb, level_out, rise_pulse, fall_pulse
    );

endinterface

// File: rtl/controller_input_conditioner_input_filter_channel.sv
// One conditioned channel: override flop, synchroniser, debounce, edges.
// Adds a saturating glitch counter with CONTROLLER_GLITCH_COUNT_EN.
module input_filter_channel
    import controller_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 3,
    parameter bit RESET_BIT    = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pin,
    input  logic       ovr_en_n,
    input  logic       ovr_val,
    input  logic [1:0] mode,
    output logic       level,
    output logic       rise,
    output logic       fall
`ifdef CONTROLLER_GLITCH_COUNT_EN
    ,
    input  logic                    glitch_clear,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CW = $clog2(FILTER_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_DEPTH - 1);

    logic                   in_r;
    logic [SYNC_STAGES-1:0] sync_q;
    filter_mode_e           mode_q;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   s;
    logic                   filt;
    logic                   level_d;

    assign s = sync_q[SYNC_STAGES-1];

    // filt: the pending transition toward s must be debounced
    always_comb begin
        filt = 1'b0;
        unique case (1'b1)
            (mode_q == MODE_AND):  filt = s;
            (mode_q == MODE_OR):   filt = ~s;
            (mode_q == MODE_SYM):  filt = 1'b1;
            (mode_q == MODE_PASS): filt = 1'b0;
        endcase
    end

    // A mode change only clears the counter; no transition that cycle
    always_comb begin
        level_d = level;
        cnt_d   = '0;
        if (mode == mode_q && s != level) begin
            if (filt && cnt != CNT_LAST) cnt_d = cnt + 1'b1;
            else level_d = s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_r   <= RESET_BIT;
            sync_q <= {SYNC_STAGES{RESET_BIT}};
            mode_q <= filter_mode_e'(mode);
            cnt    <= '0;
            level  <= RESET_BIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            in_r   <= ovr_en_n ? pin : ovr_val;
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_r};
            mode_q <= filter_mode_e'(mode);
            cnt    <= cnt_d;
            level  <= level_d;
            rise   <= level_d & ~level;
            fall   <= ~level_d & level;
        end
    end

`ifdef CONTROLLER_GLITCH_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset || glitch_clear) begin
            glitch_cnt <= '0;
        end else if (cnt != '0 && s == level && glitch_cnt != '1) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/controller_input_conditioner.sv
// Parametrised input front-end: per-channel conditioning plus io_oeb muxing.
// CONTROLLER_GLITCH_COUNT_EN adds glitch_sel/glitch_clear/glitch_count.
module controller_input_conditioner
    import controller_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 3,
    parameter logic [NUM_CHANNELS-1:0] RESET_VALUE = 3'b110,
    parameter logic [NUM_CHANNELS-1:0] OEB_DEFAULT = 3'b111,
    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input logic clock,
    input logic reset,
    controller_input_conditioner_if.slave bus
`ifdef CONTROLLER_GLITCH_COUNT_EN
    ,
    input  logic [SEL_W-1:0]        glitch_sel,
    input  logic                    glitch_clear,
    output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

    localparam int N = NUM_CHANNELS;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.io_oeb <= OEB_DEFAULT;
        end else begin
            bus.io_oeb <= (bus.la_oenb[N-1:0] & OEB_DEFAULT)
                        | (~bus.la_oenb[N-1:0] & bus.la_data_in[N-1:0]);
        end
    end

`ifdef CONTROLLER_GLITCH_COUNT_EN
    logic [GLITCH_CNT_W-1:0] gcnt [N];
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        input_filter_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_DEPTH (FILTER_DEPTH),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .pin      (bus.io_in[i]),
            .ovr_en_n (bus.la_oenb[N+i]),
            .ovr_val  (bus.la_data_in[N+i]),
            .mode     (bus.filter_mode[2*i+:2]),
            .level    (bus.level_out[i]),
            .rise     (bus.rise_pulse[i]),
            .fall     (bus.fall_pulse[i])
`ifdef CONTROLLER_GLITCH_COUNT_EN
            ,
            .glitch_clear (glitch_clear),
            .glitch_cnt   (gcnt[i])
`endif
        );
    end

`ifdef CONTROLLER_GLITCH_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            glitch_count <= '0;
        end else if (int'(glitch_sel) < N) begin
            glitch_count <= gcnt[glitch_sel];
        end else begin
            glitch_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Randomised and directed bench for controller_input_conditioner.
// Build with CONTROLLER_GLITCH_COUNT_EN to exercise glitch counting.
module tb_controller_input_conditioner;

    localparam int N  = 3;
    localparam int SS = 2;
    localparam int FD = 3;
    localparam logic [N-1:0] RV = 3'b110;
    localparam logic [N-1:0] OD = 3'b111;

    logic clock = 1'b0;
    logic reset;
    logic [1:0] glitch_sel;
    logic glitch_clear;
`ifdef CONTROLLER_GLITCH_COUNT_EN
    logic [7:0] glitch_count;
`endif
    int errors = 0;
    int checks = 0;

    controller_input_conditioner_if #(.NUM_CHANNELS(N)) bus ();

    controller_input_conditioner dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef CONTROLLER_GLITCH_COUNT_EN
        ,
        .glitch_sel   (glitch_sel),
        .glitch_clear (glitch_clear),
        .glitch_count (glitch_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference: effective pin delayed 1+SS samples, then a streak rule
    logic [N-1:0] hq [$];
    logic [N-1:0] lvl_m, rise_m, fall_m, oeb_m;
    int streak_m [N];
    int mode_m [N];
    int g_m [N];
    int gout_m;

    task automatic model_step();
        logic [N-1:0] s, e, nl;
        if (reset) begin
            hq.delete();
            for (int k = 0; k < 1 + SS; k++) hq.push_back(RV);
            lvl_m = RV; rise_m = '0; fall_m = '0; oeb_m = OD; gout_m = 0;
            for (int i = 0; i < N; i++) begin
                streak_m[i] = 0;
                mode_m[i] = int'(bus.filter_mode[2*i+:2]);
                g_m[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                e[i] = bus.la_oenb[N+i] ? bus.io_in[i] : bus.la_data_in[N+i];
                oeb_m[i] = bus.la_oenb[i] ? OD[i] : bus.la_data_in[i];
            end
            s = hq.pop_front();
            hq.push_back(e);
            gout_m = (int'(glitch_sel) < N) ? g_m[glitch_sel] : 0;
            nl = lvl_m;
            for (int i = 0; i < N; i++) begin
                int m;
                bit filt;
                m = int'(bus.filter_mode[2*i+:2]);
                filt = s[i] ? (m == 0 || m == 2) : (m == 1 || m == 2);
                if (streak_m[i] != 0 && s[i] == lvl_m[i] && g_m[i] < 255) g_m[i]++;
                if (glitch_clear) g_m[i] = 0;
                if (m != mode_m[i]) begin
                    mode_m[i] = m;
                    streak_m[i] = 0;
                end else if (s[i] == lvl_m[i]) begin
                    streak_m[i] = 0;
                end else begin
                    streak_m[i]++;
                    if (!filt || streak_m[i] >= FD) begin
                        nl[i] = s[i];
                        streak_m[i] = 0;
                    end
                end
            end
            rise_m = nl & ~lvl_m;
            fall_m = ~nl & lvl_m;
            lvl_m = nl;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks += 4;
            if (bus.level_out !== 3'b110) begin
                errors++;
                $display("FAIL reset_level cyc=%0d got=%b want=110", k, bus.level_out);
            end
            if ((bus.rise_pulse | bus.fall_pulse) !== 3'b000) begin
                errors++;
                $display("FAIL reset_pulse cyc=%0d rise=%b fall=%b want=0", k,
                         bus.rise_pulse, bus.fall_pulse);
            end
            if (bus.io_oeb !== 3'b111) begin
                errors++;
                $display("FAIL reset_oeb cyc=%0d got=%b want=111", k, bus.io_oeb);
            end
            if (bus.level_out !== lvl_m) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b want=%b", k, bus.level_out, lvl_m);
            end
        end
    endtask

    task automatic test_sym_fall();
        int fedge, fcnt, pedge;
        bit moved;
        fedge = 0; fcnt = 0; pedge = 0;
        bus.io_in[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (fedge == 0 && bus.level_out[1] == 1'b0) fedge = k;
            if (bus.fall_pulse[1]) begin
                fcnt++;
                pedge = k;
            end
        end
        checks += 3;
        if (fedge != 6) begin
            errors++;
            $display("FAIL sym_fall_latency got=%0d want=6", fedge);
        end
        if (fcnt != 1) begin
            errors++;
            $display("FAIL sym_fall_pulse_count got=%0d want=1", fcnt);
        end
        if (pedge != 6) begin
            errors++;
            $display("FAIL sym_fall_pulse_cycle got=%0d want=6", pedge);
        end
        bus.io_in[1] = 1'b1;
        repeat (10) tick();
        bus.io_in[1] = 1'b0;
        tick();
        tick();
        bus.io_in[1] = 1'b1;
        moved = 1'b0;
        repeat (12) begin
            tick();
            if (bus.level_out[1] !== 1'b1 || bus.fall_pulse[1]) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL sym_glitch_reject got=changed want=steady_1");
        end
`ifdef CONTROLLER_GLITCH_COUNT_EN
        glitch_sel = 2'd1;
        tick();
        tick();
        checks++;
        if (glitch_count !== 8'd1) begin
            errors++;
            $display("FAIL sym_glitch_count got=%0d want=1", glitch_count);
        end
`endif
    endtask

    task automatic test_or_mode();
        logic lv [13];
        logic rp [13];
        logic fp [13];
        int redge, fedge, nr, nf;
        bus.filter_mode[1:0] = 2'd1;
        repeat (3) tick();
        bus.io_in[0] = 1'b1;
        tick();
        lv[1] = bus.level_out[0]; rp[1] = bus.rise_pulse[0]; fp[1] = bus.fall_pulse[0];
        bus.io_in[0] = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            lv[k] = bus.level_out[0]; rp[k] = bus.rise_pulse[0]; fp[k] = bus.fall_pulse[0];
        end
        redge = 0; fedge = 0; nr = 0; nf = 0;
        for (int k = 1; k <= 12; k++) begin
            if (redge == 0 && lv[k]) redge = k;
            if (redge != 0 && fedge == 0 && !lv[k]) fedge = k;
            if (rp[k]) nr++;
            if (fp[k]) nf++;
        end
        checks += 4;
        if (redge != 4) begin
            errors++;
            $display("FAIL or_rise_latency got=%0d want=4", redge);
        end
        if (fedge != 7) begin
            errors++;
            $display("FAIL or_fall_latency got=%0d want=7", fedge);
        end
        if (nr != 1 || !rp[4]) begin
            errors++;
            $display("FAIL or_rise_pulse count=%0d at4=%b want=1,1", nr, rp[4]);
        end
        if (nf != 1 || !fp[7]) begin
            errors++;
            $display("FAIL or_fall_pulse count=%0d at7=%b want=1,1", nf, fp[7]);
        end
    endtask

    task automatic test_override();
        bus.filter_mode[5:4] = 2'd3;
        bus.io_in[2] = 1'b0;
        repeat (8) tick();
        checks++;
        if (bus.level_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre_level got=%b want=0", bus.level_out[2]);
        end
        bus.la_oenb[5] = 1'b0;
        bus.la_data_in[5] = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.level_out[2] !== 1'b1) begin
                errors++;
                $display("FAIL ovr_level cyc=%0d got=%b want=1", k, bus.level_out[2]);
            end
            bus.io_in[2] = 1'($urandom_range(0, 1));
            tick();
        end
        bus.la_oenb[0] = 1'b0;
        bus.la_data_in[0] = 1'b0;
        tick();
        checks++;
        if (bus.io_oeb !== 3'b110) begin
            errors++;
            $display("FAIL ovr_oeb got=%b want=110", bus.io_oeb);
        end
        bus.la_oenb = '1;
        bus.la_data_in = '0;
        bus.io_in[2] = 1'b0;
        tick();
        checks++;
        if (bus.io_oeb !== 3'b111) begin
            errors++;
            $display("FAIL ovr_oeb_release got=%b want=111", bus.io_oeb);
        end
        repeat (6) tick();
    endtask

    task automatic test_mode_switch();
        int nr;
        bus.filter_mode[5:4] = 2'd2;
        tick();
        tick();
        bus.io_in[2] = 1'b1;
        repeat (5) tick();
        bus.filter_mode[5:4] = 2'd3;
        tick();
        nr = int'(bus.rise_pulse[2]);
        checks++;
        if (bus.level_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL switch_hold got=%b want=0", bus.level_out[2]);
        end
        tick();
        nr += int'(bus.rise_pulse[2]);
        checks++;
        if (bus.level_out[2] !== 1'b1 || bus.rise_pulse[2] !== 1'b1) begin
            errors++;
            $display("FAIL switch_take level=%b rise=%b want=1,1",
                     bus.level_out[2], bus.rise_pulse[2]);
        end
        repeat (3) begin
            tick();
            nr += int'(bus.rise_pulse[2]);
        end
        checks++;
        if (nr != 1) begin
            errors++;
            $display("FAIL switch_pulses got=%0d want=1", nr);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        bus.io_in[1] = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.level_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got=%b want=1", bus.level_out[1]);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.level_out !== RV || (bus.rise_pulse | bus.fall_pulse) !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset level=%b rise=%b fall=%b want=%b,0,0",
                     bus.level_out, bus.rise_pulse, bus.fall_pulse, RV);
        end
        bus.io_in = RV;
        tick();
        reset = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (bus.level_out !== RV || (bus.rise_pulse | bus.fall_pulse) !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_release got=edge_or_change want=steady_%b", RV);
        end
    endtask

`ifdef CONTROLLER_GLITCH_COUNT_EN
    task automatic test_glitch_sat();
        bus.filter_mode[1:0] = 2'd2;
        glitch_sel = 2'd0;
        bus.io_in[0] = 1'b0;
        repeat (3) tick();
        repeat (300) begin
            bus.io_in[0] = 1'b1;
            tick();
            bus.io_in[0] = 1'b0;
            tick();
        end
        repeat (6) tick();
        checks++;
        if (glitch_count !== 8'd255 || gout_m != 255) begin
            errors++;
            $display("FAIL glitch_saturate got=%0d want=255", glitch_count);
        end
        bus.io_in[0] = 1'b1;
        tick();
        bus.io_in[0] = 1'b0;
        repeat (3) tick();
        glitch_clear = 1'b1;
        tick();
        glitch_clear = 1'b0;
        tick();
        checks++;
        if (glitch_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_clear_wins got=%0d want=0", glitch_count);
        end
        bus.io_in[0] = 1'b1;
        tick();
        bus.io_in[0] = 1'b0;
        repeat (8) tick();
        checks++;
        if (glitch_count !== 8'd1) begin
            errors++;
            $display("FAIL glitch_after_clear got=%0d want=1", glitch_count);
        end
        glitch_sel = 2'd3;
        tick();
        tick();
        checks++;
        if (glitch_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_sel_oob got=%0d want=0", glitch_count);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) bus.io_in[i] = ~bus.io_in[i];
                if ($urandom_range(0, 23) == 0) bus.filter_mode[2*i+:2] = 2'($urandom_range(0, 3));
            end
            for (int b = 0; b < 2 * N; b++) bus.la_oenb[b] = ($urandom_range(0, 7) != 0);
            bus.la_data_in = 6'($urandom);
            glitch_sel = 2'($urandom_range(0, 3));
            glitch_clear = ($urandom_range(0, 31) == 0);
            tick();
            checks += 4;
            if (bus.level_out !== lvl_m) begin
                errors++;
                $display("FAIL rnd_level cyc=%0d got=%b want=%b", k, bus.level_out, lvl_m);
            end
            if (bus.rise_pulse !== rise_m || bus.fall_pulse !== fall_m) begin
                errors++;
                $display("FAIL rnd_pulse cyc=%0d rise=%b/%b fall=%b/%b", k,
                         bus.rise_pulse, rise_m, bus.fall_pulse, fall_m);
            end
            if ((bus.rise_pulse & bus.fall_pulse) !== 3'b000) begin
                errors++;
                $display("FAIL rnd_both cyc=%0d got=%b want=000", k,
                         bus.rise_pulse & bus.fall_pulse);
            end
            if (bus.io_oeb !== oeb_m) begin
                errors++;
                $display("FAIL rnd_oeb cyc=%0d got=%b want=%b", k, bus.io_oeb, oeb_m);
            end
`ifdef CONTROLLER_GLITCH_COUNT_EN
            checks++;
            if (int'(glitch_count) != gout_m) begin
                errors++;
                $display("FAIL rnd_glitch cyc=%0d got=%0d want=%0d", k, glitch_count, gout_m);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.io_in = RV;
        bus.la_oenb = '1;
        bus.la_data_in = '0;
        bus.filter_mode = 6'b101010;
        glitch_sel = 2'd0;
        glitch_clear = 1'b0;
        test_reset();
        test_sym_fall();
        test_or_mode();
        test_override();
        test_mode_switch();
        test_reset_mid();
`ifdef CONTROLLER_GLITCH_COUNT_EN
        test_glitch_sat();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
